// File: rtl/bcd_conv_sched.sv
`default_nettype none
// ============================================================================
// Module   : bcd_conv_sched
// Brief    : Round-robin two-requester front end for a bit-serial BCD-to-binary
//            converter. Digit range checking: BCD_SCHED_RANGE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_conv_sched #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [4*DIGITS-1:0] bcd0,
    input  logic [4*DIGITS-1:0] bcd1,
    output logic [1:0]          gnt,
    output logic                busy,
    output logic                done,
    output logic                done_id,
    output logic [BIN_W-1:0]    bin_out,
    output logic                err
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     scratch_q, scratch_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             done_id_q, done_id_d;
    logic             err_q, err_d;
    logic [BIN_W-1:0] bin_q, bin_d;

    logic [W-1:0]     w_acc_sh;
    logic [W-1:0]     w_scr_rs;
    logic [W-1:0]     w_scr_adj;
    logic             w_win_id;

    // Reverse double-dabble step: LSB moves into the accumulator, then each
    // digit that came out >= 8 after the halving gets 3 removed.
    assign w_acc_sh = {scratch_q[0], acc_q[W-1:1]};
    assign w_scr_rs = scratch_q >> 1;

    always_comb begin
        w_scr_adj = w_scr_rs;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_scr_rs[4*i +: 4] >= 4'd8) begin
                w_scr_adj[4*i +: 4] = w_scr_rs[4*i +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_SCHED_RANGE_CHECK_EN
    logic w_bad;
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end
`endif

    // On a tie the requester that was not served last wins.
    assign w_win_id = (req == 2'b11) ? ~last_q : req[1];

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        id_d      = id_q;
        gnt_d     = 2'b00;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        bin_d     = bin_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (|req) begin
                    scratch_d = w_win_id ? bcd1 : bcd0;
                    acc_d     = '0;
                    id_d      = w_win_id;
                    last_d    = w_win_id;
                    gnt_d     = w_win_id ? 2'b10 : 2'b01;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_SHIFT;
                cnt_d   = '0;
`ifdef BCD_SCHED_RANGE_CHECK_EN
                if (w_bad) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    bin_d     = '1;
                    err_d     = 1'b1;
                    done_id_d = id_q;
                end
`endif
            end
            S_SHIFT: begin
                acc_d     = w_acc_sh;
                scratch_d = w_scr_adj;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    bin_d     = w_acc_sh[BIN_W-1:0];
                    err_d     = 1'b0;
                    done_id_d = id_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            scratch_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            bin_q     <= '1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            id_q      <= id_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            bin_q     <= bin_d;
            err_q     <= err_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign bin_out = bin_q;
    assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_conv_sched
// Brief    : Directed self-checking bench for bcd_conv_sched (DIGITS=2, BIN_W=7).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_conv_sched;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [7:0] bcd0;
    logic [7:0] bcd1;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic       done_id;
    logic [6:0] bin_out;
    logic       err;

    int errors = 0;
    int checks = 0;

    bcd_conv_sched #(.DIGITS(2), .BIN_W(7)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .bcd0    (bcd0),
        .bcd1    (bcd1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycles (negedges) until done is seen; -1 if it never comes.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 40);
        if (!done) lat = -1;
    endtask

    task automatic wait_gnt(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (gnt == 2'b00 && lat < 40);
        if (gnt == 2'b00) lat = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bin"},    32'(bin_out), 32'h7F);
        check({tag, "_gnt"},    32'(gnt),     32'h0);
        check({tag, "_busy"},   32'(busy),    32'h0);
        check({tag, "_done"},   32'(done),    32'h0);
        check({tag, "_err"},    32'(err),     32'h0);
        check({tag, "_doneid"}, 32'(done_id), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        rst  = 1'b1;
        req  = 2'b00;
        bcd0 = 8'h00;
        bcd1 = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-simulation with no requests
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_idle");
        @(negedge clk);
        rst = 1'b0;

        // Single conversion 47
        bcd0 = 8'h47;
        req  = 2'b01;
        @(negedge clk);
        check("single_gnt", 32'(gnt), 32'h1);
        check("single_busy", 32'(busy), 32'h1);
        req = 2'b00;
        wait_done(lat);
        check("single_lat", 32'(lat), 32'd9);
        check("single_bin", 32'(bin_out), 32'd47);
        check("single_err", 32'(err), 32'h0);
        check("single_id", 32'(done_id), 32'h0);
        @(negedge clk);
        check("single_done_pulse", 32'(done), 32'h0);
        check("single_busy_fall", 32'(busy), 32'h0);
        check("single_bin_hold", 32'(bin_out), 32'd47);

        // Contention after reset
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        bcd0 = 8'h99;
        bcd1 = 8'h00;
        req  = 2'b11;
        @(negedge clk);
        check("cont_gnt0", 32'(gnt), 32'h1);
        req = 2'b10;
        wait_done(lat);
        check("cont_lat0", 32'(lat), 32'd9);
        check("cont_bin0", 32'(bin_out), 32'd99);
        check("cont_id0", 32'(done_id), 32'h0);
        check("cont_no_early_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        check("cont_gnt1", 32'(gnt), 32'h2);
        req = 2'b00;
        wait_done(lat);
        check("cont_spacing", 32'(lat + 1), 32'd10);
        check("cont_bin1", 32'(bin_out), 32'd0);
        check("cont_id1", 32'(done_id), 32'h1);

        // Invalid digit on requester 1
        bcd1 = 8'h3A;
        req  = 2'b10;
        @(negedge clk);
        check("inv_gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        wait_done(lat);
`ifdef BCD_SCHED_RANGE_CHECK_EN
        check("inv_lat", 32'(lat), 32'd1);
        check("inv_bin", 32'(bin_out), 32'h7F);
        check("inv_err", 32'(err), 32'h1);
`else
        check("inv_lat", 32'(lat), 32'd9);
        check("inv_err", 32'(err), 32'h0);
`endif
        check("inv_id", 32'(done_id), 32'h1);
        @(negedge clk);

        // Reset in the middle of SHIFT
        bcd0 = 8'h25;
        req  = 2'b01;
        @(negedge clk);
        check("abort_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        repeat (4) @(negedge clk);
        check("abort_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) n++;
        end
        check("abort_no_done", 32'(n), 32'd0);

        // Fairness with both requests held
        bcd0 = 8'h10;
        bcd1 = 8'h21;
        req  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(lat);
            check($sformatf("fair_gnt%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i > 0) check($sformatf("fair_gap%0d", i), 32'(lat), 32'd1);
            wait_done(lat);
            check($sformatf("fair_lat%0d", i), 32'(lat), 32'd9);
            check($sformatf("fair_bin%0d", i), 32'(bin_out), (i % 2 == 0) ? 32'd10 : 32'd21);
            check($sformatf("fair_id%0d", i), 32'(done_id), (i % 2 == 0) ? 32'h0 : 32'h1);
            if (i == 3) req = 2'b00;
        end
        @(negedge clk);
        check("fair_idle_busy", 32'(busy), 32'h0);
        check("fair_idle_gnt", 32'(gnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
